// File: rtl/sched_exec_tracer.sv
// Run-length encodes the scheduler task stream into {id, start, len} records,
// buffers them in a small FIFO and keeps busy/idle utilisation counters.
module sched_exec_tracer #(
    parameter int              ID_W    = 16,
    parameter int              TIME_W  = 16,
    parameter int              LEN_W   = 8,
    parameter int              DEPTH   = 4,
    parameter logic [ID_W-1:0] IDLE_ID = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          st,
    input  logic [ID_W-1:0]               task_in,
    input  logic                          flush,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [ID_W+TIME_W+LEN_W-1:0]  rec_data,
    output logic                          overflow,
    output logic [TIME_W-1:0]             busy_cycles,
    output logic [TIME_W-1:0]             idle_cycles
);
    localparam int                AW      = $clog2(DEPTH);
    localparam int                REC_W   = ID_W + TIME_W + LEN_W;
    localparam logic [LEN_W-1:0]  LEN_MAX = '1;
    localparam logic [TIME_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_TRACE} state_t;
    state_t state, state_nxt;
    logic   active;

    logic [ID_W-1:0]   cur_id;
    logic [TIME_W-1:0] cur_start;
    logic [LEN_W-1:0]  cur_len;
    logic [TIME_W-1:0] tstamp;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, pop, push, extend, wr_en;

    // The arming cycle itself is traced, so activity covers st in S_IDLE.
    always_comb begin
        state_nxt = state;
        active    = 1'b0;
        case (state)
            S_IDLE: begin
                if (st) begin
                    state_nxt = S_TRACE;
                    active    = 1'b1;
                end
            end
            S_TRACE: active = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    assign extend = (task_in == cur_id) && (cur_id != IDLE_ID) &&
                    (cur_len != LEN_MAX) && !flush;
    assign push   = active && !extend && (cur_id != IDLE_ID);

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && rec_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en  = push && (!full || pop);

    assign rec_valid = !empty;
    assign rec_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            tstamp      <= '0;
            cur_id      <= IDLE_ID;
            cur_start   <= '0;
            cur_len     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            busy_cycles <= '0;
            idle_cycles <= '0;
        end else begin
            if (active) begin
                tstamp <= tstamp + 1'b1;
                if (task_in == IDLE_ID) begin
                    if (idle_cycles != CNT_MAX) idle_cycles <= idle_cycles + 1'b1;
                end else begin
                    if (busy_cycles != CNT_MAX) busy_cycles <= busy_cycles + 1'b1;
                end
                if (extend) begin
                    cur_len <= cur_len + 1'b1;
                end else begin
                    cur_id    <= task_in;
                    cur_start <= tstamp;
                    cur_len   <= (task_in == IDLE_ID) ? '0 : LEN_W'(1);
                end
            end
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {cur_id, cur_start, cur_len};
    end
endmodule

// File: doc/sched_exec_tracer.md
Name: sched_exec_tracer

Overview:
- Sits directly downstream of the SJF scheduler and consumes its per-cycle 16-bit task_out stream.
- Run-length encodes the stream into completion records {task id, start time, run length}, then buffers them in a small FIFO.
- Drains the records over a valid/ready port to the trace/statistics logic.
- Keeps busy and idle cycle counters for utilisation reporting.

Parameters:
- ID_W, 16: task id width; matches the scheduler task_out width.
- TIME_W, 16: width of the free-running timestamp counter.
- LEN_W, 8: width of the run-length field.
- DEPTH, 4: record FIFO depth (power of two, minimum 2).
- IDLE_ID, 16'hFFFF: id value the scheduler drives when no task runs.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- st  in  1  arm pulse; tracing starts on the first cycle st=1 is sampled.
- task_in  in  ID_W  scheduler task_out, sampled every cycle.
- flush  in  1  forces the open run to close this cycle.
- rec_valid  out  1  FIFO head holds a record.
- rec_ready  in  1  consumer accepts the head when rec_valid=1 and rec_ready=1.
- rec_data  out  ID_W+TIME_W+LEN_W  {id, start, len}; id in the MSBs.
- overflow  out  1  sticky; set when a record is dropped.
- busy_cycles  out  TIME_W  armed cycles with task_in != IDLE_ID; saturates.
- idle_cycles  out  TIME_W  armed cycles with task_in == IDLE_ID; saturates.

Behaviour:
- Reset (rst=0 at an edge), as seen after that edge:
  - rec_valid=0, rec_data=0, overflow=0, busy_cycles=0, idle_cycles=0.
  - Internal: time=0, armed=0, cur_id=IDLE_ID, cur_start=0, cur_len=0, FIFO empty.
  - Reset mid-operation discards the open run and all buffered records.
- States: S_IDLE (unarmed) and S_TRACE (armed).
  - S_IDLE->S_TRACE when st=1 is sampled. That same cycle is processed as the first traced cycle (time=0).
  - S_TRACE is left only by reset; st is ignored in S_TRACE.
- time increments once per S_TRACE cycle and wraps modulo 2^TIME_W.
- Per S_TRACE cycle, with t = current time:
  - task_in == cur_id != IDLE_ID, cur_len < 2^LEN_W-1, flush=0: cur_len += 1.
  - Otherwise the open run closes:
    - If cur_id != IDLE_ID, the record {cur_id, cur_start, cur_len} is pushed.
    - The new run is opened as cur_id=task_in, cur_start=t, cur_len=(task_in==IDLE_ID)?0:1.
  - Length saturation: when cur_len reaches 2^LEN_W-1, the next cycle of the same id closes the run and opens a new run with the same id. Long tasks are split into multiple records.
  - flush=1: closes the open run and opens a new one with the current task_in as above. flush=1 while cur_id=IDLE_ID pushes nothing.
- Idle cycles (task_in == IDLE_ID) never produce records.
- Two consecutive distinct tasks with the same id merge into one record. This is a known limitation; the scheduler never issues a duplicate id back-to-back.
- Latency: a run closing at edge k is written at edge k; rec_valid=1 from edge k on if the FIFO was empty.
- FIFO:
  - rec_data is the registered head value; rec_data=0 while empty.
  - Pop on rec_valid & rec_ready.
  - Push with FIFO full and no pop in the same cycle: record dropped, overflow set.
  - Push and pop in the same cycle when full: both occur, no drop.
  - Push and pop in the same cycle when empty: impossible, since rec_valid=0.
- Counters: busy_cycles/idle_cycles hold at 2^TIME_W-1 (no wrap). Both are frozen in S_IDLE.

Test Plan:
- rst=0 for 2 cycles, st=0, task_in=16'h0003 for 10 cycles -> rec_valid=0, busy=0, idle=0, no record.
- st pulse at t=0; task_in 0xFFFF,0x0005,0x0005,0x0005,0x0002,0xFFFF -> record {0x0005,1,3} then {0x0002,4,1}; busy=4, idle=2.
- LEN_W=8, id 0x0011 held for 300 cycles from t=0, then 0xFFFF -> records {0x0011,0,255}, {0x0011,255,45}.
- rec_ready=0, DEPTH=4, six single-cycle distinct ids -> first four records retained in order, overflow=1; then rec_ready=1 -> four pops, rec_valid=0.
- FIFO full with rec_ready=1 on the same cycle a run closes -> no drop, overflow stays 0, FIFO remains at 4 entries.
- id 0x0007 running 5 cycles, rst=0 mid-run -> rec_valid=0, all counters 0, no 0x0007 record after release; tracing resumes only on the next st.
